// File: rtl/stochastic_prng_bank.sv
// Bank of independent Galois LFSRs with per-channel seed load, autonomous warm-up
// and registered Bernoulli comparators; one shared seed FSM serialises seed writes.
module stochastic_prng_bank #(
  parameter int               WIDTH     = 16,
  parameter int               CHANNELS  = 4,
  parameter int               OUT_WIDTH = 8,
  parameter logic [WIDTH-1:0] TAP_MASK  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED_BASE = 16'hACE1,
  parameter int               WARMUP    = 16
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            advance,
  input  logic [CHANNELS-1:0]                             chan_enable,
  input  logic                                            seed_wr_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] seed_ch,
  input  logic [WIDTH-1:0]                                seed_data,
  output logic                                            seed_ready,
  output logic                                            seed_drop,
  input  logic [CHANNELS*OUT_WIDTH-1:0]                   thresh_in,
  output logic [CHANNELS*OUT_WIDTH-1:0]                   rand_out,
  output logic [CHANNELS-1:0]                             rand_valid,
  output logic [CHANNELS-1:0]                             bern_out
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {S_IDLE, S_WARMUP} seed_state_t;

  function automatic logic [WIDTH-1:0] reset_seed(input int unsigned idx);
    logic [WIDTH-1:0] s;
    s = WIDTH'(64'(SEED_BASE) + 64'(idx) * 64'h9E37);
    reset_seed = (s == '0) ? WIDTH'(1) : s;
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ TAP_MASK) : (s >> 1);
  endfunction

  seed_state_t     state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [CH_W-1:0] wch_q, wch_d;
  logic            ch_ok, accept, drop;

  assign ch_ok = (32'(seed_ch) < 32'(CHANNELS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wch_d   = wch_q;
    accept  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (seed_wr_en) begin
          if (ch_ok) begin
            accept = 1'b1;
            if (WARMUP > 0) begin
              state_d = S_WARMUP;
              cnt_d   = 8'(WARMUP);
              wch_d   = seed_ch;
            end
          end else begin
            drop = 1'b1;
          end
        end
      end
      S_WARMUP: begin
        // Writes arriving mid warm-up are rejected without touching any state.
        drop  = seed_wr_en;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      wch_q     <= '0;
      seed_drop <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wch_q     <= wch_d;
      seed_drop <= drop;
    end
  end

  assign seed_ready = (state_q == S_IDLE);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] lfsr_q;
    logic             bern_q;
    logic             load, warm;

    assign load = accept && (seed_ch == CH_W'(i));
    assign warm = (state_q == S_WARMUP) && (wch_q == CH_W'(i));

    // Load beats warm-up beats advance; a warming channel steps exactly once per edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lfsr_q <= reset_seed(i);
      end else if (load) begin
        lfsr_q <= (seed_data == '0) ? reset_seed(i) : seed_data;
      end else if (warm || (advance && chan_enable[i])) begin
        lfsr_q <= lfsr_step(lfsr_q);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bern_q <= 1'b0;
      else        bern_q <= (lfsr_q[OUT_WIDTH-1:0] < thresh_in[i*OUT_WIDTH +: OUT_WIDTH]);
    end

    assign rand_out[i*OUT_WIDTH +: OUT_WIDTH] = lfsr_q[OUT_WIDTH-1:0];
    assign rand_valid[i] = !warm;
    assign bern_out[i]   = bern_q;
  end

endmodule

// File: tb/tb_stochastic_prng_bank.sv
// Directed bench for stochastic_prng_bank at default parameters.
module tb_stochastic_prng_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        advance;
  logic [3:0]  chan_enable;
  logic        seed_wr_en;
  logic [1:0]  seed_ch;
  logic [15:0] seed_data;
  logic        seed_ready;
  logic        seed_drop;
  logic [31:0] thresh_in;
  logic [31:0] rand_out;
  logic [3:0]  rand_valid;
  logic [3:0]  bern_out;

  int vecs = 0;
  int errs = 0;
  int low_cycles, drops, ones, mism;
  logic [15:0] m [4];
  logic [31:0] prev_rand;

  stochastic_prng_bank dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .chan_enable(chan_enable),
    .seed_wr_en(seed_wr_en), .seed_ch(seed_ch), .seed_data(seed_data),
    .seed_ready(seed_ready), .seed_drop(seed_drop), .thresh_in(thresh_in),
    .rand_out(rand_out), .rand_valid(rand_valid), .bern_out(bern_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] nxt(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [7:0] ro(input int i);
    return rand_out[i*8 +: 8];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic adv_model(input logic [3:0] en, input int skip);
    for (int i = 0; i < 4; i++)
      if (i != skip && en[i]) m[i] = nxt(m[i]);
  endtask

  initial begin
    rst_n = 1'b0; advance = 1'b0; chan_enable = 4'h0; seed_wr_en = 1'b0;
    seed_ch = 2'd0; seed_data = 16'h0; thresh_in = 32'h0;
    #12;
    // Reset seeds: ACE1 + i*9E37 mod 2^16
    m = '{16'hACE1, 16'h4B18, 16'hE94F, 16'h8786};
    check("rst_ch0", 32'(ro(0)), 32'hE1);
    check("rst_ch1", 32'(ro(1)), 32'h18);
    check("rst_ch2", 32'(ro(2)), 32'h4F);
    check("rst_ch3", 32'(ro(3)), 32'h86);
    check("rst_valid", 32'(rand_valid), 32'hF);
    check("rst_ready", 32'(seed_ready), 32'h1);
    check("rst_bern", 32'(bern_out), 32'h0);
    check("rst_drop", 32'(seed_drop), 32'h0);

    @(negedge clk);
    rst_n = 1'b1; advance = 1'b1; chan_enable = 4'hF;
    tick; adv_model(4'hF, -1);
    check("adv1_ch0", 32'(ro(0)), 32'h70);
    tick; adv_model(4'hF, -1);
    check("adv2_ch0", 32'(ro(0)), 32'h38);
    check("adv2_ch1", 32'(ro(1)), 32'hC6);

    chan_enable = 4'b0101;
    tick; adv_model(4'b0101, -1);
    check("en_ch0", 32'(ro(0)), 32'h9C);
    check("en_ch1_hold", 32'(ro(1)), 32'hC6);
    check("en_ch2", 32'(ro(2)), 32'(m[2][7:0]));
    check("en_ch3_hold", 32'(ro(3)), 32'hE1);

    // Seed write ch2 with advance held high throughout
    chan_enable = 4'hF; seed_wr_en = 1'b1; seed_ch = 2'd2; seed_data = 16'h0001;
    tick; adv_model(4'hF, 2); m[2] = 16'h0001;
    seed_wr_en = 1'b0;
    check("load_ready", 32'(seed_ready), 32'h0);
    check("load_valid", 32'(rand_valid), 32'hB);
    check("load_ch2", 32'(ro(2)), 32'h01);
    low_cycles = 1; drops = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 3) begin
        seed_wr_en = 1'b1; seed_ch = 2'd2; seed_data = 16'h5555;
      end else begin
        seed_wr_en = 1'b0;
      end
      tick;
      m[2] = nxt(m[2]);
      adv_model(4'hF, 2);
      if (!seed_ready) low_cycles++;
      if (seed_drop) drops++;
    end
    seed_wr_en = 1'b0;
    check("warm_low_cycles", 32'(low_cycles), 32'd16);
    check("warm_drop_pulses", 32'(drops), 32'd1);
    check("warm_ready_back", 32'(seed_ready), 32'h1);
    check("warm_valid_back", 32'(rand_valid), 32'hF);
    check("warm_ch2", 32'(ro(2)), 32'(m[2][7:0]));
    check("warm_ch0", 32'(ro(0)), 32'(m[0][7:0]));

    // Zero seed reloads the reset seed of ch3
    advance = 1'b0; seed_wr_en = 1'b1; seed_ch = 2'd3; seed_data = 16'h0000;
    tick; seed_wr_en = 1'b0; m[3] = 16'h8786;
    check("zero_ch3", 32'(ro(3)), 32'h86);
    check("zero_valid", 32'(rand_valid), 32'h7);
    repeat (16) begin
      tick; m[3] = nxt(m[3]);
    end
    check("zero_warm_ch3", 32'(ro(3)), 32'(m[3][7:0]));
    check("zero_ready", 32'(seed_ready), 32'h1);

    // Bernoulli: threshold 0 never fires
    advance = 1'b1; chan_enable = 4'hF; thresh_in = 32'h0; ones = 0;
    repeat (20) begin
      tick; adv_model(4'hF, -1);
      if (bern_out != 4'h0) ones++;
    end
    check("bern_zero", 32'(ones), 32'd0);

    // Threshold FF: bit is set unless the sampled slice was FF
    thresh_in = {4{8'hFF}}; mism = 0;
    repeat (64) begin
      prev_rand = rand_out;
      tick; adv_model(4'hF, -1);
      for (int i = 0; i < 4; i++)
        if (bern_out[i] !== (prev_rand[i*8 +: 8] != 8'hFF)) mism++;
    end
    check("bern_ff", 32'(mism), 32'd0);

    thresh_in = {4{8'h80}}; tick; adv_model(4'hF, -1);
    ones = 0;
    repeat (4096) begin
      tick; adv_model(4'hF, -1);
      if (bern_out[0]) ones++;
    end
    check("bern_half", 32'((ones >= 1900) && (ones <= 2200)), 32'd1);
    check("long_ch0", 32'(ro(0)), 32'(m[0][7:0]));

    // Asynchronous reset in the middle of a warm-up
    advance = 1'b0; seed_wr_en = 1'b1; seed_ch = 2'd1; seed_data = 16'h1234;
    tick; seed_wr_en = 1'b0;
    repeat (5) tick;
    check("pre_abort_ready", 32'(seed_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(seed_ready), 32'h1);
    check("abort_valid", 32'(rand_valid), 32'hF);
    check("abort_ch1", 32'(ro(1)), 32'h18);
    check("abort_ch0", 32'(ro(0)), 32'hE1);
    check("abort_bern", 32'(bern_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
